// File: rtl/accel_run_ctrl_if.sv
// Host/core-facing signal bundle for the accelerator run controller.
// The controller takes the slave modport; the host/bench side takes master.
interface accel_run_ctrl_if #(
  parameter int REG_WIDTH = 32
);
  logic                 i_start;
  logic                 i_abort;
  logic                 i_host_release;
  logic [REG_WIDTH-1:0] i_conf_outputsize;
  logic                 i_psum_wr;
  logic [REG_WIDTH-1:0] o_conf_ctrl;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_error;
  logic [REG_WIDTH-1:0] o_wr_count;
  logic [REG_WIDTH-1:0] o_status;

  modport master (
    output i_start, i_abort, i_host_release, i_conf_outputsize, i_psum_wr,
    input  o_conf_ctrl, o_busy, o_done, o_error, o_wr_count, o_status
  );

  modport slave (
    input  i_start, i_abort, i_host_release, i_conf_outputsize, i_psum_wr,
    output o_conf_ctrl, o_busy, o_done, o_error, o_wr_count, o_status
  );
endinterface

// File: rtl/accel_run_ctrl.sv
// Run controller for dnn_accelerator_core: sequences a run, counts psum writes,
// drains the pipeline, then lends the psum BRAM to the host until released.
module accel_run_ctrl #(
  parameter int REG_WIDTH      = 32,
  parameter int DRAIN_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               rst,
  accel_run_ctrl_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    HOST  = 3'd3,
    ERR   = 3'd4
  } state_t;

  localparam logic [REG_WIDTH-1:0] DRAIN_LOAD   = REG_WIDTH'(DRAIN_CYCLES - 1);
  localparam logic [REG_WIDTH-1:0] TIMEOUT_LAST = REG_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [REG_WIDTH-1:0] ONE          = REG_WIDTH'(1);

  state_t               state_reg,  state_next;
  logic [REG_WIDTH-1:0] target_reg, target_next;
  logic [REG_WIDTH-1:0] count_reg,  count_next;
  logic [REG_WIDTH-1:0] gap_reg,    gap_next;
  logic [REG_WIDTH-1:0] drain_reg,  drain_next;
  // flags_reg: [2] aborted, [1] overflow, [0] timeout
  logic [2:0]           flags_reg,  flags_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      target_reg <= '0;
      count_reg  <= '0;
      gap_reg    <= '0;
      drain_reg  <= '0;
      flags_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      target_reg <= target_next;
      count_reg  <= count_next;
      gap_reg    <= gap_next;
      drain_reg  <= drain_next;
      flags_reg  <= flags_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    target_next = target_reg;
    count_next  = count_reg;
    gap_next    = gap_reg;
    drain_next  = drain_reg;
    flags_next  = flags_reg;

    case (state_reg)
      IDLE: begin
        if (bus.i_start) begin
          state_next  = RUN;
          target_next = bus.i_conf_outputsize;
          count_next  = '0;
          gap_next    = '0;
          flags_next  = '0;
        end
      end
      RUN: begin
        // Abort pre-empts everything, including a coincident write.
        if (bus.i_abort) begin
          state_next    = IDLE;
          flags_next[2] = 1'b1;
        end else if (bus.i_psum_wr) begin
          count_next = count_reg + ONE;
          gap_next   = '0;
          if (count_reg == target_reg) begin
            state_next = DRAIN;
            drain_next = DRAIN_LOAD;
          end
        end else if (gap_reg == TIMEOUT_LAST) begin
          state_next    = ERR;
          flags_next[0] = 1'b1;
        end else begin
          gap_next = gap_reg + ONE;
        end
      end
      DRAIN: begin
        if (bus.i_abort) begin
          state_next    = IDLE;
          flags_next[2] = 1'b1;
        end else if (bus.i_psum_wr) begin
          count_next    = count_reg + ONE;
          state_next    = ERR;
          flags_next[1] = 1'b1;
        end else if (drain_reg == '0) begin
          state_next = HOST;
        end else begin
          drain_next = drain_reg - ONE;
        end
      end
      HOST: begin
        // A stray core write while the host owns the BRAM is an overrun, even on release.
        if (bus.i_abort) begin
          state_next    = IDLE;
          flags_next[2] = 1'b1;
        end else if (bus.i_psum_wr) begin
          state_next    = ERR;
          flags_next[1] = 1'b1;
        end else if (bus.i_host_release) begin
          state_next = IDLE;
        end
      end
      ERR: begin
        if (bus.i_host_release) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.o_conf_ctrl = '0;
    case (state_reg)
      RUN, DRAIN: bus.o_conf_ctrl = REG_WIDTH'(32'h01);
      HOST:       bus.o_conf_ctrl = REG_WIDTH'(32'h11);
      default:    bus.o_conf_ctrl = '0;
    endcase
  end

  assign bus.o_busy     = (state_reg == RUN) || (state_reg == DRAIN);
  assign bus.o_done     = (state_reg == HOST);
  assign bus.o_error    = (state_reg == ERR);
  assign bus.o_wr_count = count_reg;
  assign bus.o_status   = {{(REG_WIDTH-6){1'b0}}, flags_reg, state_reg};

endmodule

// File: tb/tb_accel_run_ctrl.sv
// Bench for accel_run_ctrl: directed scenarios plus random traffic, all checked
// every cycle against a timestamp-based model of the run controller.
module tb_accel_run_ctrl;

  localparam int RW = 32;
  localparam int DC = 16;
  localparam int TC = 8;

  localparam int S_IDLE = 0, S_RUN = 1, S_DRAIN = 2, S_HOST = 3, S_ERR = 4;

  logic clk;
  logic rst;

  accel_run_ctrl_if #(.REG_WIDTH(RW)) bus ();

  accel_run_ctrl #(
    .REG_WIDTH(RW),
    .DRAIN_CYCLES(DC),
    .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: state plus edge timestamps of the last activity and the completing write.
  longint cyc = 0;
  int     m_state = S_IDLE;
  longint m_count = 0, m_target = 0, m_last = 0, m_final = 0;
  bit     m_to = 0, m_ov = 0, m_ab = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_state <= S_IDLE; m_count <= 0; m_target <= 0;
      m_to <= 0; m_ov <= 0; m_ab <= 0;
    end else begin
      case (m_state)
        S_IDLE: if (bus.i_start) begin
          m_state <= S_RUN; m_target <= longint'(bus.i_conf_outputsize);
          m_count <= 0; m_last <= cyc; m_to <= 0; m_ov <= 0; m_ab <= 0;
        end
        S_RUN: begin
          if (bus.i_abort) begin
            m_state <= S_IDLE; m_ab <= 1;
          end else if (bus.i_psum_wr) begin
            m_count <= m_count + 1; m_last <= cyc;
            if (m_count + 1 == m_target + 1) begin
              m_state <= S_DRAIN; m_final <= cyc;
            end
          end else if (cyc - m_last == TC) begin
            m_state <= S_ERR; m_to <= 1;
          end
        end
        S_DRAIN: begin
          if (bus.i_abort) begin
            m_state <= S_IDLE; m_ab <= 1;
          end else if (bus.i_psum_wr) begin
            m_count <= m_count + 1; m_state <= S_ERR; m_ov <= 1;
          end else if (cyc - m_final == DC) begin
            m_state <= S_HOST;
          end
        end
        S_HOST: begin
          if (bus.i_abort) begin
            m_state <= S_IDLE; m_ab <= 1;
          end else if (bus.i_psum_wr) begin
            m_state <= S_ERR; m_ov <= 1;
          end else if (bus.i_host_release) begin
            m_state <= S_IDLE;
          end
        end
        default: if (bus.i_host_release) m_state <= S_IDLE;
      endcase
    end
  end

  function automatic logic [RW-1:0] exp_conf(int s);
    if (s == S_RUN || s == S_DRAIN) return 32'h01;
    if (s == S_HOST) return 32'h11;
    return 32'h00;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cyc > 0) begin
      check("conf_ctrl", bus.o_conf_ctrl, exp_conf(m_state));
      check("busy",      bus.o_busy,  (m_state == S_RUN || m_state == S_DRAIN));
      check("done",      bus.o_done,  (m_state == S_HOST));
      check("error",     bus.o_error, (m_state == S_ERR));
      check("wr_count",  bus.o_wr_count, m_count[RW-1:0]);
      check("status",    bus.o_status, {58'd0, m_ab, m_ov, m_to, 3'(m_state)});
    end
  end

  task automatic step(input bit s, input bit a, input bit r, input bit w, input logic [RW-1:0] size);
    bus.i_start = s; bus.i_abort = a; bus.i_host_release = r; bus.i_psum_wr = w;
    bus.i_conf_outputsize = size;
    @(negedge clk);
    bus.i_start = 0; bus.i_abort = 0; bus.i_host_release = 0; bus.i_psum_wr = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.i_start = 0; bus.i_abort = 0; bus.i_host_release = 0; bus.i_psum_wr = 0;
    bus.i_conf_outputsize = '0;
    idle(2);
    check("reset_conf", bus.o_conf_ctrl, 32'h0);
    check("reset_status", bus.o_status, 32'h0);
    check("reset_count", bus.o_wr_count, 32'h0);
    rst = 1'b0;

    // Normal run, with an ignored start carrying a different size mid-run.
    step(1, 0, 0, 0, 3);
    check("run_conf", bus.o_conf_ctrl, 32'h1);
    check("run_busy", bus.o_busy, 1'b1);
    for (int i = 0; i < 4; i++) begin
      idle(4);
      step(0, 0, 0, 1, 3);
      if (i == 1) step(1, 0, 0, 0, 50);
    end
    check("drain_status", bus.o_status, 32'h2);
    idle(15);
    check("drain_not_done", bus.o_done, 1'b0);
    idle(1);
    check("host_done", bus.o_done, 1'b1);
    check("host_conf", bus.o_conf_ctrl, 32'h11);
    check("host_count", bus.o_wr_count, 32'd4);
    step(0, 0, 1, 0, 3);
    check("release_conf", bus.o_conf_ctrl, 32'h0);
    check("release_status", bus.o_status, 32'h0);

    // Timeout.
    step(1, 0, 0, 0, 9);
    idle(2); step(0, 0, 0, 1, 9);
    idle(2); step(0, 0, 0, 1, 9);
    idle(7);
    check("pre_timeout", bus.o_status, 32'h1);
    idle(1);
    check("timeout_status", bus.o_status, 32'h0C);
    check("timeout_conf", bus.o_conf_ctrl, 32'h0);
    check("timeout_count", bus.o_wr_count, 32'd2);
    step(0, 0, 1, 0, 9);
    check("timeout_flag_kept", bus.o_status, 32'h08);
    step(1, 0, 0, 0, 5);
    check("flag_cleared", bus.o_status, 32'h01);
    step(0, 1, 0, 0, 5);
    check("abort_run", bus.o_status, 32'h20);

    // Overflow in DRAIN.
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    check("single_write_drain", bus.o_status, 32'h2);
    idle(1);
    step(0, 0, 0, 1, 0);
    check("overflow_status", bus.o_status, 32'h14);
    check("overflow_count", bus.o_wr_count, 32'd2);
    step(0, 0, 1, 0, 0);

    // Abort mid-run after 10 writes.
    step(1, 0, 0, 0, 100);
    repeat (10) begin idle(1); step(0, 0, 0, 1, 100); end
    step(0, 1, 0, 0, 100);
    check("abort_status", bus.o_status, 32'h20);
    check("abort_conf", bus.o_conf_ctrl, 32'h0);
    check("abort_count", bus.o_wr_count, 32'd10);

    // Abort coinciding with the completing write.
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 1, 1);
    step(0, 1, 0, 1, 1);
    check("abort_beats_write", bus.o_status, 32'h20);

    // Release and write together in HOST.
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    idle(16);
    check("host_reached", bus.o_done, 1'b1);
    step(0, 0, 1, 1, 0);
    check("write_beats_release", bus.o_status, 32'h14);
    step(0, 0, 1, 0, 0);

    // Reset mid-DRAIN, then a clean run.
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    idle(3);
    rst = 1'b1; idle(1); rst = 1'b0;
    check("rst_conf", bus.o_conf_ctrl, 32'h0);
    check("rst_status", bus.o_status, 32'h0);
    check("rst_count", bus.o_wr_count, 32'h0);
    check("rst_busy", bus.o_busy, 1'b0);
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    idle(16);
    check("post_rst_done", bus.o_done, 1'b1);
    check("post_rst_count", bus.o_wr_count, 32'd2);
    step(0, 0, 1, 0, 1);

    // Random traffic; abort never coincides with a write here.
    for (int i = 0; i < 3000; i++) begin
      bit s, a, r, w;
      s = ($urandom_range(0, 9) == 0);
      a = ($urandom_range(0, 39) == 0);
      r = ($urandom_range(0, 9) == 0);
      w = ($urandom_range(0, 9) < 3) && !a;
      rst = ($urandom_range(0, 299) == 0);
      step(s, a, r, w, RW'($urandom_range(0, 7)));
    end
    rst = 1'b0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
